// File: rtl/counter_pkg.sv
// Shared types for the down-counter/timer slice.
package counter_pkg;

  typedef enum logic [1:0] {
    CNT_IDLE  = 2'b00,
    CNT_RUN   = 2'b01,
    CNT_PAUSE = 2'b10
  } cnt_state_t;

endpackage

// File: rtl/counter_dec_core.sv
// Combinational decrement with zero/one detection for the down-counter.
module counter_dec_core #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] dec,
  output logic             is_zero,
  output logic             is_one
);

  assign dec     = count - WIDTH'(1);
  assign is_zero = (count == '0);
  assign is_one  = (count == WIDTH'(1));

endmodule

// File: rtl/counter_down_timer.sv
// Programmable down-counter/timer: load, run, pause, one-cycle terminal pulse.
// Optional macro COUNTER_DOWN_TIMER_AUTO_RELOAD_EN reloads the preset at terminal count.
module counter_down_timer
  import counter_pkg::*;
#(
  parameter int unsigned EXPONENT = 4
) (
  input  logic                i_CLOCK_POS,
  input  logic                i_RESET_POS,
  input  logic                i_BIT_LOAD,
  input  logic [EXPONENT-1:0] i_VECTOR_PRESET,
  input  logic                i_BIT_START,
  input  logic                i_BIT_STOP,
  output logic [EXPONENT-1:0] o_VECTOR_OUT,
  output logic                o_BIT_BUSY,
  output logic                o_BIT_TERMINAL
);

  cnt_state_t          state_q;
  logic [EXPONENT-1:0] count_q;
  logic [EXPONENT-1:0] dec;
  logic                is_zero;
  logic                is_one;
  logic                terminal_q;
`ifdef COUNTER_DOWN_TIMER_AUTO_RELOAD_EN
  logic [EXPONENT-1:0] shadow_q;
`endif

  counter_dec_core #(.WIDTH(EXPONENT)) u_dec (
    .count   (count_q),
    .dec     (dec),
    .is_zero (is_zero),
    .is_one  (is_one)
  );

  always_ff @(posedge i_CLOCK_POS) begin
    if (i_RESET_POS) begin
      state_q    <= CNT_IDLE;
      count_q    <= '0;
      terminal_q <= 1'b0;
`ifdef COUNTER_DOWN_TIMER_AUTO_RELOAD_EN
      shadow_q   <= '0;
`endif
    end else begin
      terminal_q <= 1'b0;
      if (i_BIT_LOAD) begin
        count_q <= i_VECTOR_PRESET;
        state_q <= CNT_IDLE;
`ifdef COUNTER_DOWN_TIMER_AUTO_RELOAD_EN
        shadow_q <= i_VECTOR_PRESET;
`endif
      end else begin
        case (state_q)
          CNT_RUN: begin
            if (i_BIT_STOP) begin
              state_q <= CNT_PAUSE;
            end else if (is_zero || is_one) begin
              // Terminal event: pulse aligns with the post-terminal count value.
              terminal_q <= 1'b1;
`ifdef COUNTER_DOWN_TIMER_AUTO_RELOAD_EN
              count_q    <= shadow_q;
`else
              count_q    <= '0;
              state_q    <= CNT_IDLE;
`endif
            end else begin
              count_q <= dec;
            end
          end
          CNT_IDLE, CNT_PAUSE: begin
            if (i_BIT_START && !i_BIT_STOP) state_q <= CNT_RUN;
          end
          default: state_q <= CNT_IDLE;
        endcase
      end
    end
  end

  assign o_VECTOR_OUT   = count_q;
  assign o_BIT_BUSY     = (state_q == CNT_RUN);
  assign o_BIT_TERMINAL = terminal_q;

endmodule

// File: tb/tb_counter_down_timer.sv
// Directed self-checking bench for counter_down_timer (EXPONENT=4).
module tb_counter_down_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       load;
  logic [3:0] preset;
  logic       start;
  logic       stop;
  logic [3:0] out;
  logic       busy;
  logic       term;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  counter_down_timer #(.EXPONENT(4)) dut (
    .i_CLOCK_POS     (clk),
    .i_RESET_POS     (rst),
    .i_BIT_LOAD      (load),
    .i_VECTOR_PRESET (preset),
    .i_BIT_START     (start),
    .i_BIT_STOP      (stop),
    .o_VECTOR_OUT    (out),
    .o_BIT_BUSY      (busy),
    .o_BIT_TERMINAL  (term)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input int o, input int b, input int t);
    check({tag, ".out"},  32'(out),  32'(o));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".term"}, 32'(term), 32'(t));
  endtask

  task automatic do_load(input logic [3:0] p);
    load = 1'b1; preset = p;
    step();
    load = 1'b0;
    expect_state("load", int'(p), 0, 0);
  endtask

  task automatic do_start(input int p);
    start = 1'b1;
    step();
    start = 1'b0;
    expect_state("start", p, 1, 0);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; preset = '0; start = 1'b0; stop = 1'b0;

    // Reset dominates random load/start activity.
    for (int i = 0; i < 2; i++) begin
      load   = 1'($urandom_range(1));
      start  = 1'($urandom_range(1));
      preset = 4'($urandom_range(15));
      step();
      expect_state("reset", 0, 0, 0);
    end
    rst = 1'b0; load = 1'b0; start = 1'b0; preset = '0;

`ifndef COUNTER_DOWN_TIMER_AUTO_RELOAD_EN
    // Load 5 and run to terminal.
    do_load(4'd5);
    do_start(5);
    for (int i = 4; i >= 0; i--) begin
      step();
      expect_state("run5", i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0);
    end
    step();
    expect_state("run5_after", 0, 0, 0);

    // Full range 15..0 without wrap.
    do_load(4'd15);
    do_start(15);
    for (int i = 14; i >= 0; i--) begin
      step();
      expect_state("run15", i, (i != 0) ? 1 : 0, (i == 0) ? 1 : 0);
    end
    step();
    expect_state("run15_nowrap", 0, 0, 0);

    // Start from zero: single pulse, back to idle.
    do_load(4'd0);
    do_start(0);
    step();
    expect_state("zero_pulse", 0, 0, 1);
    step();
    expect_state("zero_after", 0, 0, 0);
`else
    // Auto-reload: 3,2,1,3,2,1,3 with pulse on each return to 3.
    do_load(4'd3);
    do_start(3);
    for (int i = 0; i < 6; i++) begin
      step();
      expect_state("reload3", (i % 3 == 0) ? 2 : (i % 3 == 1) ? 1 : 3, 1, (i % 3 == 2) ? 1 : 0);
    end
    step();
    expect_state("reload3_b", 2, 1, 0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_state("reload_stop", 2, 0, 0);
    step();
    expect_state("reload_hold", 2, 0, 0);

    // Preset 0 pulses every run cycle.
    do_load(4'd0);
    do_start(0);
    for (int i = 0; i < 4; i++) begin
      step();
      expect_state("reload0", 0, 1, 1);
    end
    do_load(4'd4);
`endif

    // Stop at 6, hold, resume.
    do_load(4'd9);
    do_start(9);
    for (int i = 8; i >= 6; i--) begin
      step();
      expect_state("pre_stop", i, 1, 0);
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    expect_state("pause", 6, 0, 0);
    for (int i = 0; i < 2; i++) begin
      step();
      expect_state("pause_hold", 6, 0, 0);
    end
    do_start(6);
    step();
    expect_state("resume", 5, 1, 0);

    // Load aborts a run without a pulse.
    do_load(4'd9);
    do_start(9);
    for (int i = 8; i >= 3; i--) step();
    check("abort_pre.out", 32'(out), 32'd3);
    do_load(4'd12);
    step();
    expect_state("abort_idle", 12, 0, 0);

    // Start+stop together: stop wins in IDLE and in PAUSE.
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    expect_state("ss_idle", 12, 0, 0);
    do_start(12);
    step();
    expect_state("ss_run", 11, 1, 0);
    stop = 1'b1;
    step();
    expect_state("ss_pause", 11, 0, 0);
    start = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    expect_state("ss_pause2", 11, 0, 0);
    step();
    expect_state("ss_pause3", 11, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
